// File: rtl/instr_mem_loader.sv
// Byte-serial loader that packs big-endian bytes into 32-bit instruction words and holds the CPU in reset until the image is in.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [ADDR_WIDTH:0]   Length,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  MemWrite,
    output logic [31:0]           MemAddress,
    output logic [31:0]           MemWriteData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic                  CpuHold
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                  state_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH-1:0]   word_idx_q;
    logic [1:0]              byte_idx_q;
    logic                    rdy_q, wr_q, busy_q, done_q, err_q, hold_q;
    logic [31:0]             addr_q, data_q;
    logic [ADDR_WIDTH:0]     word_cnt_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              csum_q;
`endif

    // Words completed after the current WRITE, compared at full width so Length == DEPTH works.
    assign word_cnt_d = {1'b0, word_idx_q} + (ADDR_WIDTH+1)'(1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            rdy_q      <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            wr_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (Start) begin
                        len_q      <= Length;
                        word_idx_q <= '0;
                        byte_idx_q <= '0;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                        if (Length == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else if (Length > DEPTH) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            hold_q  <= 1'b1;
                        end else begin
                            state_q <= COLLECT;
                            rdy_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            hold_q  <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (ByteValid) begin
                        case (byte_idx_q)
                            2'd0:    data_q[31:24] <= ByteIn;
                            2'd1:    data_q[23:16] <= ByteIn;
                            2'd2:    data_q[15:8]  <= ByteIn;
                            default: data_q[7:0]   <= ByteIn;
                        endcase
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ ByteIn;
`endif
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            state_q <= WRITE;
                            rdy_q   <= 1'b0;
                            wr_q    <= 1'b1;
                            addr_q  <= BASE_ADDR + 32'({word_idx_q, 2'b00});
                        end
                    end
                end
                WRITE: begin
                    if (word_cnt_d == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q <= CHECK;
                        rdy_q   <= 1'b1;
`else
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
`endif
                    end else begin
                        word_idx_q <= word_idx_q + 1'b1;
                        state_q    <= COLLECT;
                        rdy_q      <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (ByteValid) begin
                        state_q <= DONE;
                        rdy_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= (ByteIn != csum_q);
                        hold_q  <= (ByteIn != csum_q);
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ByteReady    = rdy_q;
    assign MemWrite     = wr_q;
    assign MemAddress   = addr_q;
    assign MemWriteData = data_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Error        = err_q;
    assign CpuHold      = hold_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued by the stimulus and
// popped by an independent monitor on every MemWrite strobe.
module tb_instr_mem_loader;

    localparam int AW = 10;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [AW:0]   Length = '0;
    logic [7:0]    ByteIn = '0;
    logic          ByteValid = 1'b0;
    logic          ByteReady, MemWrite, Busy, Done, Error, CpuHold;
    logic [31:0]   MemAddress, MemWriteData;

    int  vectors = 0;
    int  miscompares = 0;
    int  nwr = 0;
    wr_t exp_q[$];
    logic [7:0] bq[$];

    instr_mem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Length(Length),
        .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
        .MemWrite(MemWrite), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .Busy(Busy), .Done(Done), .Error(Error), .CpuHold(CpuHold)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge Clk);
            if (MemWrite === 1'b1) begin
                nwr++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: addr %h data %h, none expected", MemAddress, MemWriteData);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", MemAddress, e.addr);
                    chk("wr_data", MemWriteData, e.data);
                    chk("rdy_low_in_write", 32'(ByteReady), 32'h0);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        if (gap) @(negedge Clk);
        @(negedge Clk);
        ByteIn = b;
        ByteValid = 1'b1;
        while (ByteReady !== 1'b1 && t < 100) begin
            @(negedge Clk);
            t++;
        end
        if (t >= 100) chk("byte_ready_timeout", 32'(ByteReady), 32'h1);
        @(posedge Clk);
        #1 ByteValid = 1'b0;
    endtask

    // Sends every byte in bq; the checksum build also appends the correct XOR byte.
    task automatic send_queue(input bit gap);
        logic [7:0] x = 8'h0;
        foreach (bq[i]) begin
            send_byte(bq[i], gap);
            x = x ^ bq[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x, gap);
`endif
    endtask

    task automatic start(input int len);
        @(negedge Clk);
        Start = 1'b1;
        Length = (AW+1)'(len);
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (Done !== 1'b1 && t < 200) begin
            @(negedge Clk);
            t++;
        end
        chk(name, 32'(Done), 32'h1);
    endtask

    initial begin
        int w0;
        repeat (2) @(negedge Clk);
        chk("rst_ready", 32'(ByteReady), 32'h0);
        chk("rst_memwrite", 32'(MemWrite), 32'h0);
        chk("rst_addr", MemAddress, 32'h0);
        chk("rst_data", MemWriteData, 32'h0);
        chk("rst_flags", {28'h0, Busy, Done, Error, CpuHold}, 32'h1);
        Reset = 1'b0;

        // Two-word load, back-to-back bytes
        exp_q.push_back('{32'h0, 32'h20080005});
        exp_q.push_back('{32'h4, 32'h0000000C});
        start(2);
        chk("t1_busy_hold", {30'h0, Busy, CpuHold}, 32'h3);
        bq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
        send_queue(1'b0);
        wait_done("t1_done");
        chk("t1_flags", {29'h0, Busy, Error, CpuHold}, 32'h0);

        // Gapped ByteValid; CpuHold must re-assert after restart from DONE
        exp_q.push_back('{32'h0, 32'hDEADBEEF});
        start(1);
        chk("t2_restart_hold", {29'h0, Busy, Done, CpuHold}, 32'h5);
        bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_queue(1'b1);
        wait_done("t2_done");
        chk("t2_hold", 32'(CpuHold), 32'h0);

        // Length 0: done one cycle later, nothing written
        w0 = nwr;
        start(0);
        chk("t3_flags", {29'h0, Busy, Done, Error}, 32'h2);
        chk("t3_hold", 32'(CpuHold), 32'h0);
        repeat (3) @(negedge Clk);
        chk("t3_nowrite", 32'(nwr - w0), 32'h0);

        // Length exceeds memory depth
        start(1025);
        chk("t4_flags", {28'h0, Busy, Done, Error, CpuHold}, 32'h7);
        repeat (5) @(negedge Clk);
        chk("t4_nowrite", 32'(nwr - w0), 32'h0);
        chk("t4_ready", 32'(ByteReady), 32'h0);

        // Reset after two bytes of the first word
        start(1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("t5_ready", 32'(ByteReady), 32'h0);
        chk("t5_addr", MemAddress, 32'h0);
        chk("t5_data", MemWriteData, 32'h0);
        chk("t5_flags", {28'h0, Busy, Done, Error, CpuHold}, 32'h1);
        Reset = 1'b0;
        chk("t5_nowrite", 32'(nwr - w0), 32'h0);
        exp_q.push_back('{32'h0, 32'h11223344});
        start(1);
        bq = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_queue(1'b0);
        wait_done("t5_done");

        // Three words: address increments by 4
        exp_q.push_back('{32'h0, 32'h01020304});
        exp_q.push_back('{32'h4, 32'hA0B0C0D0});
        exp_q.push_back('{32'h8, 32'hFFEE0011});
        start(3);
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0,
               8'hFF, 8'hEE, 8'h00, 8'h11};
        send_queue(1'b0);
        wait_done("t6_done");
        chk("t6_flags", {29'h0, Busy, Error, CpuHold}, 32'h0);

`ifdef LOADER_CHECKSUM_EN
        exp_q.push_back('{32'h0, 32'h01020304});
        start(1);
        foreach (bq[i]) ;
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
        send_byte(8'h04, 1'b0);
        wait_done("cs_good_done");
        chk("cs_good", {30'h0, Error, CpuHold}, 32'h0);

        exp_q.push_back('{32'h0, 32'h01020304});
        start(1);
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
        send_byte(8'h05, 1'b0);
        wait_done("cs_bad_done");
        chk("cs_bad", {30'h0, Error, CpuHold}, 32'h3);
`endif

        repeat (5) @(negedge Clk);
        chk("pending_writes", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
